// File: rtl/router_fsm_if.sv
// Bundle of the source, FIFO and register-block signals seen by the 1x3
// router control FSM. The slave modport is the FSM's view; the master
// modport is the surrounding datapath (or a testbench) driving it.
interface router_fsm_if #(
  parameter int ADDR_W = 2
);
  logic              pkt_valid;
  logic [ADDR_W-1:0] data_in;
  logic              fifo_full;
  logic              fifo_empty_0;
  logic              fifo_empty_1;
  logic              fifo_empty_2;
  logic              soft_rst_0;
  logic              soft_rst_1;
  logic              soft_rst_2;
  logic              parity_done;
  logic              low_pkt_valid;

  logic              detect_add;
  logic              lfd_state;
  logic              ld_state;
  logic              laf_state;
  logic              full_state;
  logic              write_enb_reg;
  logic              rst_int_reg;
  logic              busy;

  modport slave (
    input  pkt_valid, data_in, fifo_full,
    input  fifo_empty_0, fifo_empty_1, fifo_empty_2,
    input  soft_rst_0, soft_rst_1, soft_rst_2,
    input  parity_done, low_pkt_valid,
    output detect_add, lfd_state, ld_state, laf_state, full_state,
    output write_enb_reg, rst_int_reg, busy
  );

  modport master (
    output pkt_valid, data_in, fifo_full,
    output fifo_empty_0, fifo_empty_1, fifo_empty_2,
    output soft_rst_0, soft_rst_1, soft_rst_2,
    output parity_done, low_pkt_valid,
    input  detect_add, lfd_state, ld_state, laf_state, full_state,
    input  write_enb_reg, rst_int_reg, busy
  );
endinterface

// File: rtl/router_fsm.sv
// Control FSM of the 1x3 router: header decode, payload/parity load,
// full stall and parity check for one packet at a time.
// Optional build macro ROUTER_FSM_DBG_EN adds a state_dbg[2:0] output
// carrying the raw state register.
module router_fsm #(
  parameter int ADDR_W = 2
) (
  input  logic           clk,
  input  logic           rstn,
  router_fsm_if.slave    bus
`ifdef ROUTER_FSM_DBG_EN
  ,
  output logic [2:0]     state_dbg
`endif
);

  localparam int N_SLOTS = 1 << ADDR_W;

  // Fixed encoding so the debug port always reads the same numbers.
  typedef enum logic [2:0] {
    DECODE_ADDRESS     = 3'd0,
    LOAD_FIRST_DATA    = 3'd1,
    LOAD_DATA          = 3'd2,
    LOAD_PARITY        = 3'd3,
    FIFO_FULL_STATE    = 3'd4,
    LOAD_AFTER_FULL    = 3'd5,
    WAIT_TILL_EMPTY    = 3'd6,
    CHECK_PARITY_ERROR = 3'd7
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;

  // Per-FIFO flags widened to every address code; code 3 maps to 0 so an
  // invalid address never looks empty or soft-reset.
  logic [2:0]         empty3, srst3;
  logic [N_SLOTS-1:0] empty_vec, srst_vec;

  assign empty3 = {bus.fifo_empty_2, bus.fifo_empty_1, bus.fifo_empty_0};
  assign srst3  = {bus.soft_rst_2, bus.soft_rst_1, bus.soft_rst_0};

  for (genvar gi = 0; gi < N_SLOTS; gi++) begin : g_slot
    if (gi < 3) begin : g_real
      assign empty_vec[gi] = empty3[gi];
      assign srst_vec[gi]  = srst3[gi];
    end else begin : g_none
      assign empty_vec[gi] = 1'b0;
      assign srst_vec[gi]  = 1'b0;
    end
  end

  logic din_valid;
  assign din_valid = (32'(bus.data_in) < 32'd3);

  // Next-state and address-latch logic; a soft reset of the selected FIFO
  // overrides every other transition outside DECODE_ADDRESS.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    if (state_q == DECODE_ADDRESS && bus.pkt_valid)
      addr_d = bus.data_in;

    case (state_q)
      DECODE_ADDRESS: begin
        if (bus.pkt_valid && din_valid)
          state_d = empty_vec[bus.data_in] ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
      end
      LOAD_FIRST_DATA: state_d = LOAD_DATA;
      LOAD_DATA: begin
        if (bus.fifo_full)       state_d = FIFO_FULL_STATE;
        else if (!bus.pkt_valid) state_d = LOAD_PARITY;
      end
      LOAD_PARITY: state_d = CHECK_PARITY_ERROR;
      FIFO_FULL_STATE: begin
        if (!bus.fifo_full) state_d = LOAD_AFTER_FULL;
      end
      LOAD_AFTER_FULL: begin
        if (bus.parity_done)        state_d = DECODE_ADDRESS;
        else if (bus.low_pkt_valid) state_d = LOAD_PARITY;
        else                        state_d = LOAD_DATA;
      end
      WAIT_TILL_EMPTY: begin
        if (empty_vec[addr_q]) state_d = LOAD_FIRST_DATA;
      end
      CHECK_PARITY_ERROR: begin
        state_d = bus.fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
      end
      default: state_d = DECODE_ADDRESS;
    endcase

    if (state_q != DECODE_ADDRESS && srst_vec[addr_q])
      state_d = DECODE_ADDRESS;
  end

  // State and address registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= DECODE_ADDRESS;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
    end
  end

  logic detect_add, lfd_state, ld_state, laf_state, full_state;
  logic write_enb_reg, rst_int_reg, busy;

  // Moore output decode from the registered state.
  always_comb begin
    detect_add    = 1'b0;
    lfd_state     = 1'b0;
    ld_state      = 1'b0;
    laf_state     = 1'b0;
    full_state    = 1'b0;
    write_enb_reg = 1'b0;
    rst_int_reg   = 1'b0;
    busy          = 1'b0;
    case (state_q)
      DECODE_ADDRESS:     detect_add = 1'b1;
      LOAD_FIRST_DATA:    begin lfd_state = 1'b1; write_enb_reg = 1'b1; busy = 1'b1; end
      LOAD_DATA:          begin ld_state  = 1'b1; write_enb_reg = 1'b1; end
      LOAD_PARITY:        begin write_enb_reg = 1'b1; busy = 1'b1; end
      FIFO_FULL_STATE:    begin full_state = 1'b1; busy = 1'b1; end
      LOAD_AFTER_FULL:    begin laf_state = 1'b1; write_enb_reg = 1'b1; busy = 1'b1; end
      WAIT_TILL_EMPTY:    busy = 1'b1;
      CHECK_PARITY_ERROR: begin rst_int_reg = 1'b1; busy = 1'b1; end
      default:            detect_add = 1'b1;
    endcase
  end

  assign bus.detect_add    = detect_add;
  assign bus.lfd_state     = lfd_state;
  assign bus.ld_state      = ld_state;
  assign bus.laf_state     = laf_state;
  assign bus.full_state    = full_state;
  assign bus.write_enb_reg = write_enb_reg;
  assign bus.rst_int_reg   = rst_int_reg;
  assign bus.busy          = busy;

`ifdef ROUTER_FSM_DBG_EN
  assign state_dbg = state_q;
`endif

endmodule

// File: tb/tb_router_fsm.sv
// Table-driven bench for router_fsm: each vector sets the inputs, takes one
// clock edge and compares the Moore outputs of the new state.
module tb_router_fsm;

  logic clk;
  logic rstn;

  router_fsm_if #(.ADDR_W(2)) bus ();

  router_fsm #(.ADDR_W(2)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Output byte: {detect_add, lfd, ld, laf, full, write_enb, rst_int, busy}
  localparam logic [7:0] O_DA  = 8'h80;
  localparam logic [7:0] O_LFD = 8'h45;
  localparam logic [7:0] O_LD  = 8'h24;
  localparam logic [7:0] O_LP  = 8'h05;
  localparam logic [7:0] O_FF  = 8'h09;
  localparam logic [7:0] O_LAF = 8'h15;
  localparam logic [7:0] O_WTE = 8'h01;
  localparam logic [7:0] O_CPE = 8'h03;

  typedef struct {
    logic       pv;
    logic [1:0] din;
    logic       full;
    logic [2:0] emp;
    logic [2:0] srst;
    logic       pd;
    logic       lpv;
    logic [7:0] exp;
  } vec_t;

  vec_t  vecs [128];
  string names[128];
  int    n_vec = 0;

  int checks = 0;
  int errors = 0;

  function automatic logic [7:0] outs();
    return {bus.detect_add, bus.lfd_state, bus.ld_state, bus.laf_state,
            bus.full_state, bus.write_enb_reg, bus.rst_int_reg, bus.busy};
  endfunction

  task automatic add_vec(input string nm, input logic pv, input logic [1:0] din,
                         input logic full, input logic [2:0] emp, input logic [2:0] srst,
                         input logic pd, input logic lpv, input logic [7:0] exp);
    vecs[n_vec].pv   = pv;
    vecs[n_vec].din  = din;
    vecs[n_vec].full = full;
    vecs[n_vec].emp  = emp;
    vecs[n_vec].srst = srst;
    vecs[n_vec].pd   = pd;
    vecs[n_vec].lpv  = lpv;
    vecs[n_vec].exp  = exp;
    names[n_vec]     = nm;
    n_vec++;
  endtask

  task automatic drive(input vec_t v);
    bus.pkt_valid     = v.pv;
    bus.data_in       = v.din;
    bus.fifo_full     = v.full;
    bus.fifo_empty_0  = v.emp[0];
    bus.fifo_empty_1  = v.emp[1];
    bus.fifo_empty_2  = v.emp[2];
    bus.soft_rst_0    = v.srst[0];
    bus.soft_rst_1    = v.srst[1];
    bus.soft_rst_2    = v.srst[2];
    bus.parity_done   = v.pd;
    bus.low_pkt_valid = v.lpv;
  endtask

  task automatic check(input string nm, input logic [7:0] exp);
    logic [7:0] got;
    got = outs();
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: outputs got %h expected %h", nm, got, exp);
    end else begin
      $display("ok   %s: outputs %h", nm, got);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vec_t v;

    // Idle and invalid address
    for (int i = 0; i < 2; i++) add_vec("idle", 1'b0, 2'd0, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, O_DA);
    for (int i = 0; i < 4; i++) add_vec("invalid_addr", 1'b1, 2'd3, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, O_DA);

    // Normal packet to addr 2, 14 payload bytes; soft_rst_0 mid-packet is ignored
    add_vec("norm_hdr", 1'b1, 2'd2, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, O_LFD);
    add_vec("norm_ld0", 1'b1, 2'd0, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, O_LD);
    for (int i = 0; i < 13; i++)
      add_vec("norm_ld", 1'b1, 2'd0, 1'b0, 3'b111, (i == 4) ? 3'b001 : 3'b000, 1'b0, 1'b0, O_LD);
    add_vec("norm_lp",  1'b0, 2'd0, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, O_LP);
    add_vec("norm_cpe", 1'b0, 2'd0, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, O_CPE);
    add_vec("norm_end", 1'b0, 2'd0, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, O_DA);

    // Busy destination: FIFO 1 not empty for 5 cycles
    add_vec("wait_hdr", 1'b1, 2'd1, 1'b0, 3'b101, 3'b000, 1'b0, 1'b0, O_WTE);
    for (int i = 0; i < 4; i++)
      add_vec("wait_hold", 1'b1, 2'd0, 1'b0, 3'b101, 3'b000, 1'b0, 1'b0, O_WTE);
    add_vec("wait_lfd", 1'b1, 2'd0, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, O_LFD);
    add_vec("wait_ld",  1'b1, 2'd0, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, O_LD);

    // Full stall, sub-case A: low_pkt_valid -> LOAD_PARITY
    for (int i = 0; i < 3; i++)
      add_vec("stallA_ff", 1'b1, 2'd0, 1'b1, 3'b111, 3'b000, 1'b0, 1'b0, O_FF);
    add_vec("stallA_laf", 1'b1, 2'd0, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, O_LAF);
    add_vec("stallA_lp",  1'b0, 2'd0, 1'b0, 3'b111, 3'b000, 1'b0, 1'b1, O_LP);
    add_vec("stallA_cpe", 1'b0, 2'd0, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, O_CPE);
    add_vec("stallA_end", 1'b0, 2'd0, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, O_DA);

    // Full stall, sub-case B: parity_done -> DECODE_ADDRESS
    add_vec("stallB_hdr", 1'b1, 2'd0, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, O_LFD);
    add_vec("stallB_ld",  1'b1, 2'd0, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, O_LD);
    add_vec("stallB_ff",  1'b1, 2'd0, 1'b1, 3'b111, 3'b000, 1'b0, 1'b0, O_FF);
    add_vec("stallB_laf", 1'b0, 2'd0, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, O_LAF);
    add_vec("stallB_end", 1'b0, 2'd0, 1'b0, 3'b111, 3'b000, 1'b1, 1'b1, O_DA);

    // LAF with neither flag resumes LOAD_DATA; full during CPE stalls again
    add_vec("stallC_hdr", 1'b1, 2'd0, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, O_LFD);
    add_vec("stallC_ld",  1'b1, 2'd0, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, O_LD);
    add_vec("stallC_ff",  1'b1, 2'd0, 1'b1, 3'b111, 3'b000, 1'b0, 1'b0, O_FF);
    add_vec("stallC_laf", 1'b1, 2'd0, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, O_LAF);
    add_vec("stallC_ld2", 1'b1, 2'd0, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, O_LD);
    add_vec("stallC_lp",  1'b0, 2'd0, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, O_LP);
    add_vec("stallC_cpe", 1'b0, 2'd0, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, O_CPE);
    add_vec("stallC_ff2", 1'b0, 2'd0, 1'b1, 3'b111, 3'b000, 1'b0, 1'b0, O_FF);
    add_vec("stallC_laf2",1'b0, 2'd0, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, O_LAF);
    add_vec("stallC_end", 1'b0, 2'd0, 1'b0, 3'b111, 3'b000, 1'b1, 1'b0, O_DA);

    // Soft reset of the selected FIFO aborts the packet; ignored in DECODE
    add_vec("srst_hdr",  1'b1, 2'd2, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, O_LFD);
    add_vec("srst_ld",   1'b1, 2'd0, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, O_LD);
    add_vec("srst_hit",  1'b1, 2'd0, 1'b0, 3'b111, 3'b100, 1'b0, 1'b0, O_DA);
    add_vec("srst_idle", 1'b0, 2'd0, 1'b0, 3'b111, 3'b100, 1'b0, 1'b0, O_DA);

    // Reset with a valid header presented: must not move
    rstn = 1'b0;
    v = vecs[6];
    drive(v);
    step();
    step();
    check("reset_hold", O_DA);
    rstn = 1'b1;

    for (int i = 0; i < n_vec; i++) begin
      drive(vecs[i]);
      step();
      check($sformatf("v%0d_%s", i, names[i]), vecs[i].exp);
    end

    // Asynchronous reset mid-packet returns to DECODE without a clock edge
    v = vecs[6];
    v.din = 2'd1;
    drive(v);
    step();
    check("arst_lfd", O_LFD);
    step();
    check("arst_ld", O_LD);
    #2;
    rstn = 1'b0;
    #1;
    check("arst_async", O_DA);
    step();
    rstn = 1'b1;
    v.pv = 1'b0;
    drive(v);
    step();
    check("arst_idle", O_DA);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
